// File: rtl/pulse_symbol_decoder.sv
// Synchronizes a serial line, measures each high pulse and emits a zero/one/start/err strobe.
// Latency: strobe registered on the 3rd edge after sigIn is first sampled low (2 sync + 1 decode).
// Backpressure: none; one strobe per symbol, downstream must accept every strobe.
module pulse_symbol_decoder #(
    parameter int CNT_W     = 8,
    parameter int ZERO_MIN  = 4,
    parameter int ZERO_MAX  = 8,
    parameter int ONE_MIN   = 12,
    parameter int ONE_MAX   = 16,
    parameter int START_MIN = 24,
    parameter int START_MAX = 32,
    parameter int GAP_MIN   = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic sigIn,
    output logic startBit,
    output logic oneBit,
    output logic zeroBit,
    output logic errBit,
    output logic busy
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        HIGH    = 2'd1,
        GAP     = 2'd2,
        DISCARD = 2'd3
    } state_t;

    localparam logic [CNT_W-1:0] L_SAT = '1;

    state_t             r_state, w_state_nxt;
    logic               r_s1, r_sig_sync;
    logic [CNT_W-1:0]   r_len, w_len_nxt;
    logic [CNT_W-1:0]   r_gap_cnt, w_gap_cnt_nxt;
    logic               r_start, r_one, r_zero, r_err;
    logic               w_start, w_one, w_zero, w_err;
    logic [CNT_W-1:0]   w_gap_inc;

    assign w_gap_inc = r_gap_cnt + 1'b1;

    always_comb begin
        w_state_nxt   = r_state;
        w_len_nxt     = r_len;
        w_gap_cnt_nxt = r_gap_cnt;
        w_start       = 1'b0;
        w_one         = 1'b0;
        w_zero        = 1'b0;
        w_err         = 1'b0;
        case (r_state)
            IDLE: begin
                if (r_sig_sync) begin
                    w_len_nxt   = CNT_W'(1);
                    w_state_nxt = HIGH;
                end
            end
            HIGH: begin
                if (r_sig_sync) begin
                    if (r_len != L_SAT) w_len_nxt = r_len + 1'b1;
                end else begin
                    // Saturated length lies above START_MAX, so it falls through to err.
                    if (r_len >= CNT_W'(ZERO_MIN) && r_len <= CNT_W'(ZERO_MAX))
                        w_zero = 1'b1;
                    else if (r_len >= CNT_W'(ONE_MIN) && r_len <= CNT_W'(ONE_MAX))
                        w_one = 1'b1;
                    else if (r_len >= CNT_W'(START_MIN) && r_len <= CNT_W'(START_MAX))
                        w_start = 1'b1;
                    else
                        w_err = 1'b1;
                    w_gap_cnt_nxt = CNT_W'(1);
                    w_state_nxt   = GAP;
                end
            end
            GAP: begin
                if (r_sig_sync) begin
                    w_err       = 1'b1;
                    w_state_nxt = DISCARD;
                end else begin
                    w_gap_cnt_nxt = w_gap_inc;
                    if (w_gap_inc >= CNT_W'(GAP_MIN)) w_state_nxt = IDLE;
                end
            end
            DISCARD: begin
                if (!r_sig_sync) begin
                    w_gap_cnt_nxt = CNT_W'(1);
                    w_state_nxt   = GAP;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= IDLE;
            r_s1       <= 1'b0;
            r_sig_sync <= 1'b0;
            r_len      <= '0;
            r_gap_cnt  <= '0;
            r_start    <= 1'b0;
            r_one      <= 1'b0;
            r_zero     <= 1'b0;
            r_err      <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_s1       <= sigIn;
            r_sig_sync <= r_s1;
            r_len      <= w_len_nxt;
            r_gap_cnt  <= w_gap_cnt_nxt;
            r_start    <= w_start;
            r_one      <= w_one;
            r_zero     <= w_zero;
            r_err      <= w_err;
        end
    end

    assign startBit = r_start;
    assign oneBit   = r_one;
    assign zeroBit  = r_zero;
    assign errBit   = r_err;
    assign busy     = (r_state != IDLE);

endmodule
